// File: rtl/simple_up_counter.sv
// simple_up_counter: free-running modulo up counter with synchronous reset.
// The count runs 0..MODULUS-1, wraps to 0, and loads RESET_VALUE on reset.
// The output comes straight from the state register.
module simple_up_counter #(
   parameter int unsigned     WIDTH       = 4,
   parameter longint unsigned MODULUS     = 64'd1 << WIDTH,
   parameter longint unsigned RESET_VALUE = 64'd0
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] count
);

   // Terminal value and reset load, truncated once to the register width.
   // When MODULUS == 2**WIDTH, LAST is all ones.
   // The explicit compare then gives the same result as natural overflow.
   localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 64'd1);
   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: increment, or wrap to zero from the terminal value.
   always_comb begin
      count_d = count_q + WIDTH'(1);
      if (count_q == LAST) begin
         count_d = '0;
      end
   end

   // Count register. Reset takes priority over wrap and increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= RST_VAL;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_simple_up_counter.sv
// Bench for simple_up_counter.
// Two instances run on a shared clock and reset:
//   a - default configuration, period 16.
//   b - WIDTH=4, MODULUS=10, RESET_VALUE=3.
// Each vector record holds a reset input and the expected counts.
// The records are pushed to a scoreboard when driven.
// They are popped and compared one time unit after the rising edge.
module tb_simple_up_counter;

   typedef struct {
      logic       rst;
      logic [3:0] exp_a;
      logic [3:0] exp_b;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [3:0] count_a;
   logic [3:0] count_b;

   vec_t vecs[$];
   vec_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   k_since_rst = 0;

   simple_up_counter u_dut_a (
      .clk   (clk),
      .rst   (rst),
      .count (count_a)
   );

   simple_up_counter #(
      .WIDTH       (4),
      .MODULUS     (10),
      .RESET_VALUE (3)
   ) u_dut_b (
      .clk   (clk),
      .rst   (rst),
      .count (count_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected counts come from the number of edges since the last reset.
   // Instance a is that number mod 16.
   // Instance b is 3 plus that number, mod 10.
   task automatic add_vec(input logic r);
      vec_t v;
      if (r) k_since_rst = 0;
      else   k_since_rst = k_since_rst + 1;
      v.rst   = r;
      v.exp_a = 4'(k_since_rst % 16);
      v.exp_b = 4'((3 + k_since_rst) % 10);
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [3:0] act, input logic [3:0] exp);
      vectors = vectors + 1;
      if (act !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   // Drive one record at the falling edge and push it to the scoreboard.
   // Then pop it and compare one time unit after the rising edge.
   task automatic run_vec(input vec_t v, input int idx);
      vec_t e;
      @(negedge clk);
      rst = v.rst;
      sb.push_back(v);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         vectors = vectors + 1;
         miscompares = miscompares + 1;
         $display("FAIL scoreboard step %0d: got empty queue expected entry", idx);
      end else begin
         e = sb.pop_front();
         check("count_a", idx, count_a, e.exp_a);
         check("count_b", idx, count_b, e.exp_b);
      end
   endtask

   initial begin
      rst = 1'b0;

      // Reset is held for two edges (25 and 35 ns).
      add_vec(1'b1);
      add_vec(1'b1);
      // Free run from 45 ns.
      // Instance a reaches 15 at 185 ns, wraps at 195 ns, and reaches 9 at 285 ns.
      for (int i = 0; i < 25; i++) add_vec(1'b0);
      // Reset while a is at 9, then one increment.
      add_vec(1'b1);
      add_vec(1'b0);
      // Run a up to 15, then reset it there.
      for (int i = 0; i < 14; i++) add_vec(1'b0);
      add_vec(1'b1);
      add_vec(1'b0);
      // Run b up to 9, then reset it there.
      for (int i = 0; i < 5; i++) add_vec(1'b0);
      add_vec(1'b1);
      add_vec(1'b0);

      // The first falling edge (10 ns) is left idle.
      // This makes reset rise at 20 ns.
      @(negedge clk);
      foreach (vecs[i]) run_vec(vecs[i], i);

      // Reset raised between edges must not change the count before the next edge.
      // After the table, a=1 and b=4.
      // The next run edge gives a=2 and b=5.
      begin
         vec_t v;
         v.rst = 1'b0; v.exp_a = 4'd2; v.exp_b = 4'd5;
         run_vec(v, 900);
      end
      #1 rst = 1'b1;
      #2;
      check("midcycle_a", 901, count_a, 4'd2);
      check("midcycle_b", 901, count_b, 4'd5);
      @(posedge clk);
      #1;
      check("rst_edge_a", 902, count_a, 4'd0);
      check("rst_edge_b", 902, count_b, 4'd3);
      begin
         vec_t v;
         v.rst = 1'b0; v.exp_a = 4'd1; v.exp_b = 4'd4;
         run_vec(v, 903);
      end

      if (sb.size() != 0) begin
         vectors = vectors + 1;
         miscompares = miscompares + 1;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
